cmos_capture_ctrl: RTL and testbench
====================================

Name: cmos_capture_ctrl

Overview:
Frame-level sequencer for the CMOS capture path. After sensor configuration completes, it discards settling frames, then drives the capture enable, which the capture datapath samples on each vsync falling edge. It supports single-shot and continuous modes and ping-pongs between two downstream frame buffers. A vsync watchdog detects a stalled sensor.

Parameters:
SKIP_FRAMES, 10, frames discarded after cfg_done before the first capture (0 = no skip)
TIMEOUT_CYC, 2000000, maximum clk cycles between vsync falling edges before an error is raised
PIX_PER_FRAME, 307200, expected cap_vld beats per frame (640x480); used only by the optional check
FCNT_W, 16, width of frame_cnt

Ports:
clk  in  1  system clock, same domain as the capture datapath
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a capture session
stop  in  1  one-cycle pulse: end the session after the current frame
mode_cont  in  1  1 = continuous, 0 = single frame; latched on start
cfg_done  in  1  level: sensor register configuration finished
vsync  in  1  raw sensor vsync, already synchronous to clk
buf_rdy  in  1  level: buffer selected by buf_sel is free to be written
cap_vld  in  1  capture datapath pixel-valid strobe
cap_eop  in  1  capture datapath end-of-frame strobe
clr_err  in  1  one-cycle pulse: leave ERR state
en_capture  out  1  capture enable to the datapath
buf_sel  out  1  destination buffer index for the current or next frame
frame_cnt  out  FCNT_W  completed captured frames; wraps modulo 2^FCNT_W
frame_done  out  1  one-cycle pulse on each captured frame end
busy  out  1  high in every state except IDLE and ERR
timeout_err  out  1  sticky watchdog error
frame_err  out  1  only with CAP_FRAME_CHECK_EN: one-cycle pulse on a pixel count mismatch

Behaviour:
- Reset values: en_capture 0, buf_sel 0, frame_cnt 0, frame_done 0, busy 0, timeout_err 0, frame_err 0, state IDLE, all counters 0. All outputs are registered.
- vs_fall is high when the previous vsync sample is 1 and the current sample is 0 (one flop plus compare). This is the only frame-start event.
- States and encodings: IDLE=0, WAIT_CFG=1, SKIP=2, ARM=3, CAP=4, ERR=5.
- IDLE:
  - On start: latch mode_cont and clear stop_req.
  - If cfg_done is already 1, go to SKIP, or to ARM when SKIP_FRAMES==0. Otherwise go to WAIT_CFG.
  - start is ignored in every state other than IDLE.
- WAIT_CFG: on cfg_done=1, go to SKIP, or to ARM when SKIP_FRAMES==0.
- SKIP: skip_cnt increments on each vs_fall. On the vs_fall where skip_cnt==SKIP_FRAMES-1, go to ARM.
- ARM:
  - en_capture is registered from buf_rdy each cycle, so a buf_rdy drop removes it one cycle later.
  - On vs_fall with en_capture==1, go to CAP. The datapath has latched the enable on that same edge.
- CAP:
  - en_capture is forced to 0 on the cycle after entry, so the datapath drops its capture flag at the next vs_fall.
  - On cap_eop (1 cycle): frame_done pulses next cycle, frame_cnt increments, and buf_sel toggles.
  - After cap_eop: go to ARM if mode_cont is latched and stop_req==0. Otherwise go to IDLE.
- stop:
  - In WAIT_CFG, SKIP or ARM: go to IDLE next cycle and clear en_capture.
  - Exception: stop coincident with vs_fall while en_capture==1 in ARM. Go to CAP with stop_req set, so the started frame completes.
  - In CAP: set stop_req only.
- Watchdog:
  - wd_cnt counts cycles in SKIP, ARM and CAP. It clears on vs_fall and on every state entry.
  - When wd_cnt reaches TIMEOUT_CYC-1: go to ERR, set timeout_err=1, clear en_capture.
- ERR: busy=0 and en_capture=0. On clr_err, clear timeout_err and go to IDLE.
- Simultaneous events:
  - Watchdog expiry wins over every other event.
  - cap_eop and stop in the same cycle: the frame is counted, then go to IDLE.
  - rst mid-frame returns everything to reset values immediately (asynchronous). buf_sel returns to 0.

Optional Feature:
CAP_FRAME_CHECK_EN
- Defined:
  - pix_cnt (19 bits) counts cap_vld in CAP. It clears on CAP entry.
  - On cap_eop, compare pix_cnt including the eop beat against PIX_PER_FRAME. On mismatch, pulse frame_err for 1 cycle, and frame_cnt still increments.
  - cap_vld outside CAP is ignored.
- Undefined: no pix_cnt logic. frame_err is tied to 0 and cap_vld is unused.

Test Plan:
1. SKIP_FRAMES=2; cfg_done=1, start, mode_cont=0, buf_rdy=1; 4 vsync frames -> en_capture rises after 2nd vs_fall; CAP entered on 3rd vs_fall; after cap_eop: frame_done 1 pulse, frame_cnt=1, buf_sel=1, state IDLE, busy=0.
2. Continuous, buf_rdy=1, 3 frames then stop mid-3rd frame -> frame_cnt=3, buf_sel toggles 1,0,1, IDLE after 3rd cap_eop, no 4th capture.
3. Continuous, buf_rdy=0 across one vs_fall in ARM -> en_capture stays 0, that frame skipped; buf_rdy=1 -> next frame captured, frame_cnt increments by 1 only.
4. TIMEOUT_CYC=1000, vsync held high in ARM -> ERR after 1000 cycles, timeout_err=1, en_capture=0; clr_err -> IDLE, timeout_err=0.
5. start with cfg_done=0, raise cfg_done after 50 cycles -> WAIT_CFG held 50 cycles, then SKIP; rst asserted mid-CAP -> all outputs reset values in same cycle.
6. With CAP_FRAME_CHECK_EN, PIX_PER_FRAME=16: frame with 16 cap_vld -> no frame_err; frame with 15 -> frame_err one pulse, frame_cnt still increments.

Source files
------------

// File: rtl/cmos_capture_ctrl.sv
// Frame-level sequencer for the CMOS capture path: skip, arm, capture, ping-pong.
// Define CAP_FRAME_CHECK_EN to enable the per-frame pixel count check.
module cmos_capture_ctrl #(
  parameter int SKIP_FRAMES   = 10,
  parameter int TIMEOUT_CYC   = 2000000,
  parameter int PIX_PER_FRAME = 307200,
  parameter int FCNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_cont,
  input  logic              cfg_done,
  input  logic              vsync,
  input  logic              buf_rdy,
  input  logic              cap_vld,
  input  logic              cap_eop,
  input  logic              clr_err,
  output logic              en_capture,
  output logic              buf_sel,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              frame_done,
  output logic              busy,
  output logic              timeout_err,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CFG = 3'd1,
    SKIP     = 3'd2,
    ARM      = 3'd3,
    CAP      = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam int SK_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam state_t CFG_NXT = (SKIP_FRAMES == 0) ? ARM : SKIP;

  state_t          state, state_nxt;
  logic            vs_d, vs_fall;
  logic            mode_q, mode_nxt;
  logic            stop_req, stop_req_nxt;
  logic [SK_W-1:0] skip_cnt, skip_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            wd_on, wd_exp;
  logic            en_nxt, eop_hit;

  assign vs_fall = vs_d & ~vsync;
  assign wd_on   = (state == SKIP) || (state == ARM) || (state == CAP);
  assign wd_exp  = wd_on && (32'(wd_cnt) == TIMEOUT_CYC - 1);

  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode_q;
    stop_req_nxt = stop_req;
    skip_nxt     = skip_cnt;
    eop_hit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_nxt     = mode_cont;
          stop_req_nxt = 1'b0;
          state_nxt    = cfg_done ? CFG_NXT : WAIT_CFG;
        end
      end
      WAIT_CFG: begin
        if (stop) state_nxt = IDLE;
        else if (cfg_done) state_nxt = CFG_NXT;
      end
      SKIP: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (vs_fall) begin
          if (32'(skip_cnt) == SKIP_FRAMES - 1) state_nxt = ARM;
          else skip_nxt = skip_cnt + 1'b1;
        end
      end
      ARM: begin
        // a frame already latched by the datapath is always completed
        if (vs_fall && en_capture) begin
          state_nxt = CAP;
          if (stop) stop_req_nxt = 1'b1;
        end else if (stop) begin
          state_nxt = IDLE;
        end
      end
      CAP: begin
        if (stop) stop_req_nxt = 1'b1;
        if (cap_eop) begin
          eop_hit   = 1'b1;
          state_nxt = (mode_q && !stop_req && !stop) ? ARM : IDLE;
        end
      end
      ERR: begin
        if (clr_err) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (wd_exp) begin
      state_nxt = ERR;
      eop_hit   = 1'b0;
    end
    if (state_nxt != SKIP) skip_nxt = '0;
    if ((state_nxt != state) || vs_fall || !wd_on) wd_nxt = '0;
    else wd_nxt = wd_cnt + 1'b1;
    en_nxt = (state_nxt == ARM) ? buf_rdy : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vs_d        <= 1'b0;
      mode_q      <= 1'b0;
      stop_req    <= 1'b0;
      skip_cnt    <= '0;
      wd_cnt      <= '0;
      en_capture  <= 1'b0;
      buf_sel     <= 1'b0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_d       <= vsync;
      mode_q     <= mode_nxt;
      stop_req   <= stop_req_nxt;
      skip_cnt   <= skip_nxt;
      wd_cnt     <= wd_nxt;
      en_capture <= en_nxt;
      frame_done <= eop_hit;
      busy       <= (state_nxt != IDLE) && (state_nxt != ERR);
      if (eop_hit) begin
        frame_cnt <= frame_cnt + 1'b1;
        buf_sel   <= ~buf_sel;
      end
      if (wd_exp) timeout_err <= 1'b1;
      else if (state == ERR && clr_err) timeout_err <= 1'b0;
    end
  end

`ifdef CAP_FRAME_CHECK_EN
  logic [18:0] pix_cnt;
  logic [31:0] pix_tot;

  // the eop beat itself may carry a pixel
  assign pix_tot = 32'(pix_cnt) + 32'(cap_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= eop_hit && (pix_tot != 32'(PIX_PER_FRAME));
      if (state_nxt == CAP && state != CAP) pix_cnt <= '0;
      else if (state == CAP && cap_vld) pix_cnt <= pix_cnt + 1'b1;
    end
  end
`else
  logic unused;

  assign unused    = cap_vld ^ (PIX_PER_FRAME == 0);
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Randomized self-checking bench for cmos_capture_ctrl.
// Frame-level model: counts captured frames, buffer parity, pixel mismatches.
module tb_cmos_capture_ctrl;

  localparam int SKIP = 2;
  localparam int TMO  = 1000;
  localparam int PIX  = 16;
  localparam int FW   = 16;
`ifdef CAP_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0, stop = 0, mode_cont = 0, cfg_done = 0;
  logic          vsync = 0, buf_rdy = 0, cap_vld = 0, cap_eop = 0;
  logic          clr_err = 0;
  logic          en_capture, buf_sel, frame_done, busy;
  logic          timeout_err, frame_err;
  logic [FW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_done = 0;
  int exp_errs = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  cmos_capture_ctrl #(
    .SKIP_FRAMES  (SKIP),
    .TIMEOUT_CYC  (TMO),
    .PIX_PER_FRAME(PIX),
    .FCNT_W       (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode_cont  (mode_cont),
    .cfg_done   (cfg_done),
    .vsync      (vsync),
    .buf_rdy    (buf_rdy),
    .cap_vld    (cap_vld),
    .cap_eop    (cap_eop),
    .clr_err    (clr_err),
    .en_capture (en_capture),
    .buf_sel    (buf_sel),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .busy       (busy),
    .timeout_err(timeout_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sess(input bit cont, input bit cfg);
    mode_cont = cont;
    cfg_done  = cfg;
    start     = 1;
    step();
    start = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got %0b want 1", busy);
    end
  endtask

  // one sensor frame; the bench plays the datapath, latching en on vs_fall
  task automatic do_frame(input int npix, input bit exp_cap,
                          input int stop_at, input bit stop_fall);
    bit lat;
    bit e_err;
    vsync = 1;
    repeat (4) step();
    vsync = 0;
    lat   = en_capture;
    stop  = stop_fall;
    step();
    stop = 0;
    checks++;
    if (lat !== exp_cap) begin
      errors++;
      $display("FAIL capture_decision got %0b want %0b", lat, exp_cap);
    end
    if (lat) begin
      for (int i = 0; i < npix; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          cap_vld = 0;
          step();
        end
        cap_vld = 1;
        cap_eop = (i == npix - 1);
        stop    = (i == stop_at);
        step();
        if (i == 0) begin
          checks++;
          if ({en_capture, busy} !== 2'b01) begin
            errors++;
            $display("FAIL cap_en_busy got %b want 01", {en_capture, busy});
          end
        end
      end
      cap_vld = 0;
      cap_eop = 0;
      stop    = 0;
      e_err   = CHK && (npix != PIX);
      if (exp_cap) begin
        exp_frames++;
        exp_done++;
        if (e_err) exp_errs++;
      end
      checks++;
      if (frame_done !== 1'b1 || frame_cnt !== FW'(exp_frames) ||
          buf_sel !== exp_frames[0] || frame_err !== e_err) begin
        errors++;
        $display("FAIL frame_end got done=%0b cnt=%0d sel=%0b ferr=%0b want 1 %0d %0b %0b",
                 frame_done, frame_cnt, buf_sel, frame_err,
                 FW'(exp_frames), exp_frames[0], e_err);
      end
    end
    repeat (3) step();
  endtask

  task automatic chk_idle(input string nm);
    checks++;
    if ({busy, en_capture} !== 2'b00) begin
      errors++;
      $display("FAIL %s got busy/en %b want 00", nm, {busy, en_capture});
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst = 0;
    step();
    checks++;
    if ({en_capture, buf_sel, frame_cnt, frame_done, busy, timeout_err,
         frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {en_capture, buf_sel, frame_cnt, frame_done, busy,
                timeout_err, frame_err});
    end
  endtask

  task automatic test_single();
    buf_rdy = 1;
    begin_sess(0, 1);
    do_frame($urandom_range(8, 20), 0, -1, 0);
    checks++;
    if (en_capture !== 1'b0) begin
      errors++;
      $display("FAIL skip_en got %0b want 0", en_capture);
    end
    do_frame($urandom_range(8, 20), 0, -1, 0);
    checks++;
    if (en_capture !== 1'b1) begin
      errors++;
      $display("FAIL arm_en got %0b want 1", en_capture);
    end
    do_frame($urandom_range(8, 20), 1, -1, 0);
    chk_idle("single_idle");
    do_frame($urandom_range(8, 20), 0, -1, 0);
  endtask

  task automatic test_continuous();
    int n, np;
    buf_rdy = 1;
    begin_sess(1, 1);
    repeat (SKIP) do_frame($urandom_range(8, 20), 0, -1, 0);
    n = $urandom_range(3, 5);
    for (int k = 0; k < n; k++) begin
      np = $urandom_range(8, 20);
      do_frame(np, 1, (k == n - 1) ? $urandom_range(0, np - 1) : -1, 0);
    end
    chk_idle("cont_stop_idle");
    do_frame($urandom_range(8, 20), 0, -1, 0);
  endtask

  task automatic test_buf_rdy();
    bit rdy;
    buf_rdy = 1;
    begin_sess(1, 1);
    repeat (SKIP) do_frame($urandom_range(8, 20), 0, -1, 0);
    for (int k = 0; k < 6; k++) begin
      rdy = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      buf_rdy = rdy;
      do_frame($urandom_range(8, 20), rdy, -1, 0);
    end
    stop = 1;
    step();
    stop = 0;
    chk_idle("arm_stop_idle");
    buf_rdy = 1;
  endtask

  task automatic test_stop_on_vsfall();
    buf_rdy = 1;
    begin_sess(1, 1);
    repeat (SKIP) do_frame($urandom_range(8, 20), 0, -1, 0);
    do_frame($urandom_range(8, 20), 1, -1, 1);
    chk_idle("vsfall_stop_idle");
    do_frame($urandom_range(8, 20), 0, -1, 0);
  endtask

  task automatic test_frame_check();
    buf_rdy = 1;
    begin_sess(1, 1);
    repeat (SKIP) do_frame($urandom_range(8, 20), 0, -1, 0);
    do_frame(PIX, 1, -1, 0);
    do_frame(PIX - 1, 1, -1, 0);
    do_frame(PIX + 1, 1, 0, 0);
    chk_idle("fcheck_idle");
  endtask

  task automatic test_watchdog();
    int n;
    buf_rdy = 1;
    begin_sess(0, 1);
    do_frame($urandom_range(8, 20), 0, -1, 0);
    vsync = 1;
    repeat (4) step();
    vsync = 0;
    step();
    vsync = 1;
    n = 0;
    while (timeout_err !== 1'b1 && n < TMO + 100) begin
      step();
      n++;
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL wd_latency got %0d want %0d", n, TMO);
    end
    chk_idle("err_outputs");
    start = 1;
    step();
    start = 0;
    checks++;
    if ({busy, timeout_err} !== 2'b01) begin
      errors++;
      $display("FAIL err_start_ignored got %b want 01", {busy, timeout_err});
    end
    clr_err = 1;
    step();
    clr_err = 0;
    checks++;
    if ({busy, timeout_err} !== 2'b00) begin
      errors++;
      $display("FAIL clr_err got %b want 00", {busy, timeout_err});
    end
    vsync = 0;
    step();
  endtask

  task automatic test_wait_cfg_rst();
    buf_rdy = 1;
    begin_sess(0, 0);
    for (int i = 0; i < 50; i++) begin
      vsync = ((i % 10) < 3);
      step();
    end
    checks++;
    if ({busy, en_capture} !== 2'b10) begin
      errors++;
      $display("FAIL wait_cfg got busy/en %b want 10", {busy, en_capture});
    end
    cfg_done = 1;
    step();
    repeat (SKIP) do_frame($urandom_range(8, 20), 0, -1, 0);
    vsync = 1;
    repeat (4) step();
    vsync = 0;
    step();
    cap_vld = 1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midcap_busy got %0b want 1", busy);
    end
    #3 rst = 1;
    #1;
    checks++;
    if ({en_capture, buf_sel, frame_cnt, frame_done, busy, timeout_err,
         frame_err} !== '0) begin
      errors++;
      $display("FAIL async_rst got %b want 0",
               {en_capture, buf_sel, frame_cnt, frame_done, busy,
                timeout_err, frame_err});
    end
    #2 rst = 0;
    cap_vld    = 0;
    exp_frames = 0;
    step();
  endtask

  task automatic test_pulses();
    repeat (3) step();
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL done_pulses got %0d want %0d", done_cnt, exp_done);
    end
    checks++;
    if (err_cnt != exp_errs) begin
      errors++;
      $display("FAIL err_pulses got %0d want %0d", err_cnt, exp_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_buf_rdy();
    test_stop_on_vsfall();
    test_frame_check();
    test_watchdog();
    test_wait_cfg_rst();
    test_single();
    test_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
